lfsr_seq_ctrl: RTL
==================

# lfsr_seq_ctrl

Command-driven sequencer for a parameterizable Fibonacci LFSR. It accepts a configuration command (seed, tap mask, word count), loads the generator, and streams a requested number of pseudo-random words over a valid/ready interface with full backpressure. It reports completion, and it rejects the all-zero lock-up seed. The block sits between a configuration master (CPU register file or test sequencer) and any downstream consumer of pseudo-random patterns.

## Interface
Parameters:
- WIDTH, 8, LFSR state/word width (≥ 2)
- CNT_W, 16, width of the word-count field

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accepted when cfg_valid && cfg_ready
- cfg_seed  in  WIDTH  initial LFSR state
- cfg_taps  in  WIDTH  feedback tap mask, bit i = state bit i participates
- cfg_len  in  CNT_W  number of words to emit
- stop  in  1  abort the current run
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- out_data  out  WIDTH  current LFSR state
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at end of run (normal or aborted)
- seed_err  out  1  one-cycle pulse: zero seed rejected

## Operation
- Step function: next = {state[WIDTH-2:0], ^(state & taps)}. Shift left, feedback into LSB.
- FSM states: IDLE, RUN, DONE.
- IDLE: cfg_ready=1. On accept:
  - seed≠0, len≠0: state<=seed, taps latched, remaining<=len, go to RUN.
  - seed==0: seed_err pulses next cycle, stay IDLE, registers unchanged.
  - seed≠0, len==0: go directly to DONE; no word emitted.
- RUN: out_valid=1, out_data=state. On handshake (out_valid && out_ready): state<=next, remaining--. A handshake with remaining==1 → DONE.
- stop in RUN → DONE. If stop and a handshake coincide, the word counts as transferred, then the block goes to DONE.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
- cfg_valid is ignored outside IDLE; cfg_ready=0 there.
- stop is ignored in IDLE/DONE.
- Latched taps hold for the whole run; cfg_* changes mid-run have no effect.
- out_data is held stable while out_valid && !out_ready.

## Timing
- Reset values: FSM=IDLE, state=0, remaining=0, cfg_ready=1, out_valid=0, out_data=0, busy=0, done=0, seed_err=0.
- All outputs are registered or decoded from FSM state only; there is no combinational path from out_ready/stop to out_valid.
- Command accepted at edge t → out_valid=1 and out_data=seed in cycle t+1.
- With out_ready tied high, one word per cycle. len words occupy cycles t+1..t+len, done in cycle t+len+1, cfg_ready in cycle t+len+2.
- len==0 command: done in cycle t+1.
- Zero seed: seed_err in cycle t+1, cfg_ready stays 1.
- Remaining counter never wraps: it decrements only in RUN on handshake, where it is ≥ 1.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous), and the run is discarded.

## Structure
- lfsr_pkg: FSM state enum (IDLE, RUN, DONE) and the lfsr_step(state, taps) function.
- Sub-module lfsr_core: holds the state register with load/advance enables and computes next. lfsr_seq_ctrl holds the FSM, counter, and handshakes.

## Test plan
- WIDTH=4, taps=4'b1001, seed=4'b0001, len=15, out_ready=1 → out_data 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8. Single done pulse one cycle after the last word.
- Same command, out_ready toggled pseudo-randomly → identical 15-word sequence, no duplicates or drops, out_data stable while stalled.
- seed=0, len=5 → seed_err pulse in cycle t+1, out_valid never rises, cfg_ready stays 1. seed=4'b0010, taps=4'b1010, len=6 → 2,5,A,4,8,1.
- len=0 → done in cycle t+1, no out_valid.
- len=10, stop asserted in the same cycle as the 3rd handshake → exactly 3 words transferred, done next cycle, then IDLE. A cfg_valid pulse during RUN is ignored.
- Reset asserted mid-run with out_valid=1 → out_valid=0, busy=0, cfg_ready=1 immediately. A new command afterwards restarts from its seed.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR step function for the LFSR sequencer.
// Contents: FSM state enum, maximum supported width, lfsr_step().
// lfsr_step works on zero-extended vectors; callers truncate to their width.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Fibonacci step: shift left, parity of tapped bits into the LSB.
    // With zero-extended operands the bits above the real width do not
    // affect the parity, so truncating the result gives the correct step.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with a latched tap mask, load and advance enables.
// Ports: clk/reset, load (seed+taps), advance (one step), seed, taps in; state out.
// Load has priority over advance; state and taps reset to zero.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] taps_q;
    logic [WIDTH-1:0] next_state;

    assign next_state = WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(taps_q)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= '0;
            taps_q <= '0;
        end else if (load) begin
            state  <= seed;
            taps_q <= taps;
        end else if (advance) begin
            state  <= next_state;
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven LFSR sequencer: accepts seed/taps/len, streams len words.
// Ports: cfg_* command handshake, stop, out_* valid/ready stream, busy/done/seed_err status.
// Every status/handshake output is a register; out_data is the LFSR state register.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [WIDTH-1:0] cfg_taps,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             stop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);

    fsm_t             fsm;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             seed_zero;
    logic             len_zero;
    logic             load;
    logic             handshake;

    // cfg_ready is high exactly in IDLE, so it doubles as the IDLE decode.
    assign accept    = cfg_valid && cfg_ready;
    assign seed_zero = (cfg_seed == '0);
    assign len_zero  = (cfg_len == '0);
    assign load      = accept && !seed_zero && !len_zero;
    // out_valid is high exactly in RUN.
    assign handshake = out_valid && out_ready;

    lfsr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (handshake),
        .seed    (cfg_seed),
        .taps    (cfg_taps),
        .state   (out_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= ST_IDLE;
            remaining <= '0;
            cfg_ready <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            seed_err <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (accept) begin
                        if (seed_zero) begin
                            // Lock-up seed: flag it and stay ready.
                            seed_err <= 1'b1;
                        end else if (len_zero) begin
                            fsm       <= ST_DONE;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            fsm       <= ST_RUN;
                            remaining <= cfg_len;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                    // A stop coinciding with a handshake still lets that word count.
                    if (stop || (handshake && remaining == CNT_W'(1))) begin
                        fsm       <= ST_DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    fsm       <= ST_IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    fsm       <= ST_IDLE;
                    cfg_ready <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
